// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for a single-word CPU SRAM port.
// CPU reads are registered (1-cycle latency). A 2-entry loader FIFO fills the
// array in the background. CPU writes always win the single array write port,
// and a blocked drain is counted in stall_count.
module sram_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sram_EN,
    input  logic              sram_WE,
    input  logic [ADDR_W-1:0] sram_ADDR,
    input  logic [DATA_W-1:0] sram_DI,
    output logic [DATA_W-1:0] sram_DO,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_pending,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       stall_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Loader FIFO storage; only the pointers and occupancy are reset, so a
    // reset discards whatever was buffered.
    logic [ADDR_W-1:0] buf_addr [2];
    logic [DATA_W-1:0] buf_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic [1:0]        occ_next;

    logic              cpu_rd;
    logic              cpu_wr;
    logic              accept;
    logic              drain;
    logic              stall;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  drain_idx;

    // The modulo keeps every address bit in use and still wraps correctly
    // when DEPTH is not a power of two.
    assign cpu_idx   = IDX_W'(32'(sram_ADDR) % 32'(DEPTH));
    assign drain_idx = IDX_W'(32'(buf_addr[rd_ptr]) % 32'(DEPTH));

    assign cpu_rd       = sram_EN & ~sram_WE;
    assign cpu_wr       = sram_EN & sram_WE;
    assign accept       = load_valid & load_ready;
    assign drain        = (occ != 2'd0) & ~cpu_wr;
    assign stall        = (occ != 2'd0) & cpu_wr;
    assign load_pending = (occ != 2'd0);

    // Next occupancy: accept and drain on the same edge cancel out.
    always_comb begin
        occ_next = occ;
        case ({accept, drain})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Control state, registered read data and trace counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            load_ready  <= 1'b1;
            sram_DO     <= '0;
            rd_count    <= 32'd0;
            wr_count    <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            occ        <= occ_next;
            load_ready <= (occ_next != 2'd2);
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            if (cpu_rd) begin
                sram_DO  <= mem[cpu_idx];
                rd_count <= rd_count + 32'd1;
            end
            if (cpu_wr) begin
                wr_count <= wr_count + 32'd1;
            end
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    // Capture an offered loader word into the tail slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_addr[wr_ptr] <= load_addr;
            buf_data[wr_ptr] <= load_data;
        end
    end

    // Single array write port: CPU write first, otherwise the FIFO head.
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            mem[cpu_idx] <= sram_DI;
        end else if (drain) begin
            mem[drain_idx] <= buf_data[rd_ptr];
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of sram_responder with hand-computed
// expected values, covering reads, writes, loader flow and mid-cycle reset.
module tb_sram_responder;

    logic        clk;
    logic        reset;
    logic        sram_EN;
    logic        sram_WE;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic [31:0] sram_DO;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_pending;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [31:0] stall_count;

    int vectors;
    int miscompares;

    sram_responder #(
        .ADDR_W(16),
        .DATA_W(32),
        .DEPTH (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sram_EN     (sram_EN),
        .sram_WE     (sram_WE),
        .sram_ADDR   (sram_ADDR),
        .sram_DI     (sram_DI),
        .sram_DO     (sram_DO),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_pending(load_pending),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .stall_count (stall_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive every DUT input for the coming edge.
    task automatic apply_stimulus(input logic en, input logic we, input logic [15:0] addr,
                                  input logic [31:0] di, input logic lv,
                                  input logic [15:0] la, input logic [31:0] ld);
        sram_EN    = en;
        sram_WE    = we;
        sram_ADDR  = addr;
        sram_DI    = di;
        load_valid = lv;
        load_addr  = la;
        load_data  = ld;
    endtask

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        step();

        check_output("rst_do", sram_DO, 32'd0);
        check_output("rst_ready", 32'(load_ready), 32'd1);
        check_output("rst_pending", 32'(load_pending), 32'd0);
        check_output("rst_rd", rd_count, 32'd0);
        check_output("rst_wr", wr_count, 32'd0);
        check_output("rst_stall", stall_count, 32'd0);
        reset = 1'b1;

        // Preload addr 5 = 0x11 and addr 20 = 0x7 through the loader.
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd5, 32'h11);
        step();
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd20, 32'h7);
        step();
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("preload_pending", 32'(load_pending), 32'd0);

        // Read addr 5.
        check_output("rd5_before", sram_DO, 32'd0);
        apply_stimulus(1'b1, 1'b0, 16'd5, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd5_after", sram_DO, 32'h11);
        check_output("rd5_count", rd_count, 32'd1);

        // Write addr 3, then read it back.
        apply_stimulus(1'b1, 1'b1, 16'd3, 32'hDEADBEEF, 1'b0, 16'd0, 32'd0);
        step();
        check_output("wr3_do_hold", sram_DO, 32'h11);
        check_output("wr3_count", wr_count, 32'd1);
        apply_stimulus(1'b1, 1'b0, 16'd3, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd3", sram_DO, 32'hDEADBEEF);
        check_output("rd3_count", rd_count, 32'd2);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("idle_hold", sram_DO, 32'hDEADBEEF);

        // Three back-to-back loader words with the CPU idle.
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd10, 32'd1);
        step();
        check_output("ld10_ready", 32'(load_ready), 32'd1);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd11, 32'd2);
        step();
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd12, 32'd3);
        step();
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("ld3_pending", 32'(load_pending), 32'd0);
        apply_stimulus(1'b1, 1'b0, 16'd10, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd10", sram_DO, 32'd1);
        apply_stimulus(1'b1, 1'b0, 16'd11, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd11", sram_DO, 32'd2);
        apply_stimulus(1'b1, 1'b0, 16'd12, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd12", sram_DO, 32'd3);

        // One buffered entry held off by three CPU writes.
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd30, 32'hA);
        step();
        apply_stimulus(1'b1, 1'b1, 16'd40, 32'h100, 1'b0, 16'd0, 32'd0);
        step();
        apply_stimulus(1'b1, 1'b1, 16'd41, 32'h101, 1'b0, 16'd0, 32'd0);
        step();
        apply_stimulus(1'b1, 1'b1, 16'd42, 32'h102, 1'b0, 16'd0, 32'd0);
        step();
        check_output("stall3", stall_count, 32'd3);
        check_output("stall_pending", 32'(load_pending), 32'd1);
        check_output("stall_wr", wr_count, 32'd4);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("stall_drained", 32'(load_pending), 32'd0);
        check_output("stall_hold", stall_count, 32'd3);
        apply_stimulus(1'b1, 1'b0, 16'd30, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd30", sram_DO, 32'hA);

        // Fill the buffer behind CPU writes; ready reopens one cycle after a drain.
        apply_stimulus(1'b1, 1'b1, 16'd50, 32'h1, 1'b1, 16'd31, 32'hB);
        step();
        apply_stimulus(1'b1, 1'b1, 16'd51, 32'h2, 1'b1, 16'd32, 32'hC);
        step();
        check_output("full_ready", 32'(load_ready), 32'd0);
        check_output("full_pending", 32'(load_pending), 32'd1);
        check_output("full_stall", stall_count, 32'd4);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd3, 32'h0BAD);
        step();
        check_output("reopen_ready", 32'(load_ready), 32'd1);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("full_drained", 32'(load_pending), 32'd0);
        check_output("full_wr", wr_count, 32'd6);
        apply_stimulus(1'b1, 1'b0, 16'd3, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd3_not_loaded", sram_DO, 32'hDEADBEEF);
        apply_stimulus(1'b1, 1'b0, 16'd31, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd31", sram_DO, 32'hB);
        apply_stimulus(1'b1, 1'b0, 16'd32, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rd32", sram_DO, 32'hC);

        // Drain and CPU read of the same address on one edge.
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 16'd20, 32'h55);
        step();
        apply_stimulus(1'b1, 1'b0, 16'd20, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rbw_old", sram_DO, 32'h7);
        apply_stimulus(1'b1, 1'b0, 16'd20, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("rbw_new", sram_DO, 32'h55);
        check_output("rbw_rd", rd_count, 32'd11);

        // Asynchronous reset mid-cycle with two entries buffered.
        apply_stimulus(1'b1, 1'b1, 16'd60, 32'h1, 1'b1, 16'd10, 32'h99);
        step();
        apply_stimulus(1'b1, 1'b1, 16'd61, 32'h2, 1'b1, 16'd11, 32'h98);
        step();
        check_output("pre_rst_pending", 32'(load_pending), 32'd1);
        check_output("pre_rst_ready", 32'(load_ready), 32'd0);
        apply_stimulus(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0);
        #3;
        reset = 1'b0;
        #1;
        check_output("arst_do", sram_DO, 32'd0);
        check_output("arst_rd", rd_count, 32'd0);
        check_output("arst_wr", wr_count, 32'd0);
        check_output("arst_stall", stall_count, 32'd0);
        check_output("arst_pending", 32'(load_pending), 32'd0);
        check_output("arst_ready", 32'(load_ready), 32'd1);
        step();
        reset = 1'b1;
        step();
        step();
        apply_stimulus(1'b1, 1'b0, 16'd10, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("post_rst_rd10", sram_DO, 32'd1);
        apply_stimulus(1'b1, 1'b0, 16'd11, 32'd0, 1'b0, 16'd0, 32'd0);
        step();
        check_output("post_rst_rd11", sram_DO, 32'd2);
        check_output("post_rst_rdcnt", rd_count, 32'd2);
        check_output("post_rst_pending", 32'(load_pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
